// File: rtl/obufds_ser_tx.sv
// Multi-channel differential serializing output buffer with a one-word holding register.
// Define OBUFDS_SER_TX_MSB_FIRST_EN to shift each channel MSB first instead of LSB first.
module obufds_ser_tx #(
    parameter int   CHANNELS   = 4,
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                         CLK,
    input  logic                         RSTN,
    input  logic                         GTS,
    input  logic [CHANNELS*WIDTH-1:0]    DIN,
    input  logic                         DVALID,
    output logic                         DREADY,
    output logic                         BUSY,
    output logic [CHANNELS-1:0]          O,
    output logic [CHANNELS-1:0]          OB
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    state_t                       r_state;
    logic                         r_rdy;
    logic                         r_hfull;
    logic                         r_busy;
    logic [CHANNELS*WIDTH-1:0]    r_h;
    logic [CHANNELS*WIDTH-1:0]    r_s;
    logic [CW-1:0]                r_cnt;
    logic [CHANNELS-1:0]          r_oq;

    logic                         w_xfer;
    logic                         w_float;
    logic [CW-1:0]                w_cnt_nxt;
    logic [CHANNELS-1:0]          w_din_b0;
    logic [CHANNELS-1:0]          w_h_b0;
    logic [CHANNELS-1:0]          w_s_bit;

    // Gathers bit n (in shift order) of every channel of a word.
    function automatic logic [CHANNELS-1:0] pick(
        input logic [CHANNELS*WIDTH-1:0] word,
        input logic [CW-1:0]             n
    );
        logic [CHANNELS-1:0] r;
        int                  idx;
        r = '0;
`ifdef OBUFDS_SER_TX_MSB_FIRST_EN
        idx = WIDTH - 1 - int'(n);
`else
        idx = int'(n);
`endif
        for (int c = 0; c < CHANNELS; c++) begin
            r[c] = word[c*WIDTH + idx];
        end
        return r;
    endfunction

    assign DREADY    = r_rdy && !r_hfull;
    assign BUSY      = r_busy;
    assign w_xfer    = DVALID && DREADY;
    assign w_float   = GTS || !RSTN;
    assign w_cnt_nxt = (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    assign w_din_b0  = pick(DIN, '0);
    assign w_h_b0    = pick(r_h, '0);
    assign w_s_bit   = pick(r_s, r_cnt);

    assign O  = w_float ? {CHANNELS{1'bz}} : r_oq;
    assign OB = w_float ? {CHANNELS{1'bz}} : ~r_oq;

    // r_cnt is the index of the next bit to drive; it wraps to 0 while the
    // last bit of a word sits on the output register.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= ST_IDLE;
            r_rdy   <= 1'b0;
            r_hfull <= 1'b0;
            r_busy  <= 1'b0;
            r_h     <= '0;
            r_s     <= '0;
            r_cnt   <= '0;
            r_oq    <= {CHANNELS{IDLE_LEVEL}};
        end else begin
            r_rdy <= 1'b1;
            unique case (r_state)
                ST_IDLE: begin
                    if (r_hfull) begin
                        r_s     <= r_h;
                        r_oq    <= w_h_b0;
                        r_cnt   <= CW'(1);
                        r_hfull <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SHIFT;
                    end else if (w_xfer) begin
                        r_s     <= DIN;
                        r_oq    <= w_din_b0;
                        r_cnt   <= CW'(1);
                        r_busy  <= 1'b1;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (r_cnt != '0) begin
                        r_oq  <= w_s_bit;
                        r_cnt <= w_cnt_nxt;
                        if (w_xfer) begin
                            r_h     <= DIN;
                            r_hfull <= 1'b1;
                        end
                    end else if (r_hfull) begin
                        r_s     <= r_h;
                        r_oq    <= w_h_b0;
                        r_cnt   <= CW'(1);
                        r_hfull <= w_xfer;
                        if (w_xfer) begin
                            r_h <= DIN;
                        end
                    end else if (w_xfer) begin
                        r_s   <= DIN;
                        r_oq  <= w_din_b0;
                        r_cnt <= CW'(1);
                    end else begin
                        r_oq    <= {CHANNELS{IDLE_LEVEL}};
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_obufds_ser_tx.sv
// Bench for obufds_ser_tx: directed steps plus random traffic checked
// against a queue model of the per-cycle pad bit stream.
module tb_obufds_ser_tx;

    localparam int CH = 2;
    localparam int W  = 4;

    logic            CLK;
    logic            RSTN;
    logic            GTS;
    logic [CH*W-1:0] DIN;
    logic            DVALID;
    logic            DREADY;
    logic            BUSY;
    logic [CH-1:0]   O;
    logic [CH-1:0]   OB;

    int n_cmp;
    int n_bad;

    logic [1:0] bq[$];
    logic [1:0] m_oq;
    logic       m_busy;
    logic       m_rdy;

    obufds_ser_tx #(
        .CHANNELS   (CH),
        .WIDTH      (W),
        .IDLE_LEVEL (1'b0)
    ) dut (
        .CLK    (CLK),
        .RSTN   (RSTN),
        .GTS    (GTS),
        .DIN    (DIN),
        .DVALID (DVALID),
        .DREADY (DREADY),
        .BUSY   (BUSY),
        .O      (O),
        .OB     (OB)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [1:0] obs,
                       input logic [1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic m_ready();
        return m_rdy && (bq.size() < W);
    endfunction

    task automatic model_reset();
        bq.delete();
        m_oq   = 2'b00;
        m_busy = 1'b0;
        m_rdy  = 1'b0;
    endtask

    task automatic check_all(input string tag);
        logic fl;
        fl = GTS || !RSTN;
        chk({tag, ".O"},  O,  fl ? 2'bzz : m_oq);
        chk({tag, ".OB"}, OB, fl ? 2'bzz : ~m_oq);
        chk({tag, ".DREADY"}, {1'b0, DREADY}, {1'b0, m_ready()});
        chk({tag, ".BUSY"},   {1'b0, BUSY},   {1'b0, m_busy});
    endtask

    // One clock: drive inputs, advance the model at the edge, check at negedge.
    task automatic cycle(input string tag, input logic v,
                         input logic [7:0] d, input logic g);
        logic x;
        int   idx;
        DVALID = v;
        DIN    = d;
        GTS    = g;
        x = v && m_ready() && RSTN;
        @(posedge CLK);
        if (RSTN) begin
            if (x) begin
                for (int n = 0; n < W; n++) begin
`ifdef OBUFDS_SER_TX_MSB_FIRST_EN
                    idx = W - 1 - n;
`else
                    idx = n;
`endif
                    bq.push_back({d[W + idx], d[idx]});
                end
            end
            if (bq.size() > 0) begin
                m_oq   = bq.pop_front();
                m_busy = 1'b1;
            end else begin
                m_oq   = 2'b00;
                m_busy = 1'b0;
            end
            m_rdy = 1'b1;
        end
        @(negedge CLK);
        check_all(tag);
    endtask

    task automatic send(input string tag, input logic [7:0] d);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            done = m_ready();
            cycle(tag, 1'b1, d, 1'b0);
        end
        chk({tag, ".accepted"}, {1'b0, done}, 2'b01);
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        RSTN   = 1'b0;
        GTS    = 1'b0;
        DVALID = 1'b0;
        DIN    = '0;
        model_reset();

        // Reset hold and release
        #1;
        check_all("rst0");
        repeat (3) cycle("rst", 1'b0, 8'h00, 1'b0);
        RSTN = 1'b1;
        #1;
        chk("rel.O",  O,  2'b00);
        chk("rel.OB", OB, 2'b11);
        chk("rel.DREADY", {1'b0, DREADY}, 2'b00);
        @(negedge CLK);
        cycle("rdy", 1'b0, 8'h00, 1'b0);
        chk("rdy.DREADY", {1'b0, DREADY}, 2'b01);

        // Single word: first bit on O right after the accept edge
        cycle("w1", 1'b1, 8'hA5, 1'b0);
`ifdef OBUFDS_SER_TX_MSB_FIRST_EN
        chk("w1.bit0", O, 2'b10);
`else
        chk("w1.bit0", O, 2'b01);
`endif
        repeat (6) cycle("w1", 1'b0, 8'h00, 1'b0);

        // Back-to-back words with DVALID held
        send("b2b", 8'hA5);
        send("b2b", 8'h3C);
        repeat (10) cycle("b2b", 1'b0, 8'h00, 1'b0);

        // GTS for one cycle mid-word
        cycle("gts", 1'b1, 8'hA5, 1'b0);
        cycle("gts", 1'b0, 8'h00, 1'b0);
        cycle("gts", 1'b0, 8'h00, 1'b1);
        repeat (4) cycle("gts", 1'b0, 8'h00, 1'b0);

        // Reset in the middle of a word
        cycle("mrst", 1'b1, 8'hA5, 1'b0);
        cycle("mrst", 1'b0, 8'h00, 1'b0);
        #2;
        RSTN = 1'b0;
        #1;
        model_reset();
        check_all("mrst.async");
        repeat (2) cycle("mrst", 1'b0, 8'h00, 1'b0);
        RSTN = 1'b1;
        #1;
        chk("mrst.rel.O", O, 2'b00);
        @(negedge CLK);
        repeat (5) cycle("mrst.post", 1'b0, 8'h00, 1'b0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle("rand", 1'($urandom_range(0, 2) != 0),
                  8'($urandom), 1'($urandom_range(0, 9) == 0));
        end
        repeat (12) cycle("drain", 1'b0, 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
